// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/execute sequencer for register-to-register ALU instructions; done follows
// the last step by one cycle (unary 6, binary 7, wide 8 cycles from start); stalls in T1 on mem_ready.
module alu_instr_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int ALU_W    = 12
) (
    input  logic                clock,
    input  logic                clr,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCout,
    output logic                PCin,
    output logic                incPC,
    output logic                MARin,
    output logic                MDRread,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlow_in,
    output logic                Zhigh_in,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                LOin,
    output logic                HIin,
    output logic [ALU_W-1:0]    ALUin,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [2:0]          tstate
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_T0 = 3'd1, S_T1 = 3'd2, S_T2 = 3'd3,
        S_T3   = 3'd4, S_T4 = 3'd5, S_T5 = 3'd6, S_T6 = 3'd7
    } state_t;

    state_t state, state_nxt;
    logic   t1_wait;
    logic   done_nxt;
    logic   illegal_set;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_bin, is_wide, is_unary, bad;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    assign is_bin   = (opcode <= 5'd12);
    assign is_wide  = (opcode == 5'd13) || (opcode == 5'd14);
    assign is_unary = (opcode == 5'd15) || (opcode == 5'd16);
    // Rc is only an operand for the binary class.
    assign bad = !(is_bin || is_wide || is_unary)
               || (int'(ra) >= NUM_REGS) || (int'(rb) >= NUM_REGS)
               || (is_bin && (int'(rc) >= NUM_REGS));

    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = (int'(idx) == i);
        return v;
    endfunction

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state   <= S_IDLE;
            t1_wait <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Marks T1 stall cycles so the PC update is issued only once.
            t1_wait <= (state == S_T1) && !mem_ready;
            done    <= done_nxt;
            if (illegal_set)
                illegal <= 1'b1;
            else if (state == S_IDLE && start)
                illegal <= 1'b0;
        end
    end

    always_comb begin
        state_nxt   = state;
        done_nxt    = 1'b0;
        illegal_set = 1'b0;
        Rin         = '0;
        Rout        = '0;
        PCout       = 1'b0;
        PCin        = 1'b0;
        incPC       = 1'b0;
        MARin       = 1'b0;
        MDRread     = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zlow_in     = 1'b0;
        Zhigh_in    = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        LOin        = 1'b0;
        HIin        = 1'b0;
        ALUin       = '0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_T0;
            S_T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                incPC     = 1'b1;
                Zlow_in   = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                MDRread = 1'b1;
                MDRin   = 1'b1;
                if (!t1_wait) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
                if (mem_ready) state_nxt = S_T2;
            end
            S_T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                if (bad) begin
                    illegal_set = 1'b1;
                    state_nxt   = S_IDLE;
                end else if (is_unary) begin
                    Rout      = onehot(rb);
                    ALUin     = ALU_W'(opcode);
                    Zlow_in   = 1'b1;
                    Zhigh_in  = 1'b1;
                    state_nxt = S_T4;
                end else begin
                    Rout      = is_bin ? onehot(rb) : onehot(ra);
                    Yin       = 1'b1;
                    state_nxt = S_T4;
                end
            end
            S_T4: begin
                if (is_unary) begin
                    Zlowout   = 1'b1;
                    Rin       = onehot(ra);
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    Rout      = is_bin ? onehot(rc) : onehot(rb);
                    ALUin     = ALU_W'(opcode);
                    Zlow_in   = 1'b1;
                    Zhigh_in  = is_wide;
                    state_nxt = S_T5;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_bin) begin
                    Rin       = onehot(ra);
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    LOin      = 1'b1;
                    state_nxt = S_T6;
                end
            end
            S_T6: begin
                Zhighout  = 1'b1;
                HIin      = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign tstate = state;

endmodule
